// File: rtl/coeff_rle_pkg.sv
// rtl/coeff_rle_pkg.sv - shared types and constants for the coefficient run-length coder
//
// Purpose: FSM state enum and default sizing constants used by every coeff_rle file.
// Ports:   none (package).
package coeff_rle_pkg;

  localparam int NCOEF_DEF = 32;
  localparam int CW_DEF    = 64;
  localparam int RUN_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    EOB
  } state_t;

endpackage

// File: rtl/coeff_rle_if.sv
// rtl/coeff_rle_if.sv - block-in / token-out handshake bundle for coeff_rle
//
// Purpose: groups the block input handshake and the token output handshake.
// Ports (signals):
//   in_valid, in_ready, in_coeffs[NCOEF*CW]      block input
//   out_valid, out_ready, out_run, out_value,    token output
//   out_eob
// Modports: master = block producer / token consumer, slave = coeff_rle.
interface coeff_rle_if #(
  parameter int NCOEF = coeff_rle_pkg::NCOEF_DEF,
  parameter int CW    = coeff_rle_pkg::CW_DEF
) ();
  import coeff_rle_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [NCOEF*CW-1:0]   in_coeffs;
  logic                  out_valid;
  logic                  out_ready;
  logic [RUN_W-1:0]      out_run;
  logic [CW-1:0]         out_value;
  logic                  out_eob;

  modport master (
    output in_valid, in_coeffs, out_ready,
    input  in_ready, out_valid, out_run, out_value, out_eob
  );

  modport slave (
    input  in_valid, in_coeffs, out_ready,
    output in_ready, out_valid, out_run, out_value, out_eob
  );

endinterface

// File: rtl/coeff_rle_sel.sv
// rtl/coeff_rle_sel.sv - combinational coefficient selector
//
// Purpose: picks coefficient idx out of the captured block and flags it nonzero.
// Ports:
//   blk  in  NCOEF*CW  captured block, coefficient i at [i*CW +: CW]
//   idx  in  IW        coefficient index
//   coef out CW        selected coefficient
//   nz   out 1         selected coefficient has any bit set
module coeff_rle_sel #(
  parameter int NCOEF = coeff_rle_pkg::NCOEF_DEF,
  parameter int CW    = coeff_rle_pkg::CW_DEF,
  parameter int IW    = $clog2(NCOEF)
) (
  input  logic [NCOEF*CW-1:0] blk,
  input  logic [IW-1:0]       idx,
  output logic [CW-1:0]       coef,
  output logic                nz
);

  assign coef = blk[idx*CW +: CW];
  assign nz   = |coef;

endmodule

// File: rtl/coeff_rle.sv
// rtl/coeff_rle.sv - zig-zag coefficient run-length coder (run, value, eob tokens)
//
// Purpose: accepts a block of NCOEF coefficients, emits a DC token, one token per
//          later nonzero coefficient carrying the preceding zero run, then EOB.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of coeff_rle_if (block in, token out)
// Options: COEFF_RLE_DC_DIFF_EN - DC token carries coef0 minus the previous block's coef0.
module coeff_rle #(
  parameter int NCOEF = coeff_rle_pkg::NCOEF_DEF,
  parameter int CW    = coeff_rle_pkg::CW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  coeff_rle_if.slave bus
);
  import coeff_rle_pkg::*;

  localparam int            IW   = $clog2(NCOEF);
  localparam logic [IW-1:0] LAST = IW'(NCOEF - 1);

  state_t              state;
  logic [IW-1:0]       idx;
  logic [RUN_W-1:0]    run;
  logic [NCOEF*CW-1:0] blk;
  logic [CW-1:0]       coef;
  logic                nz;
  logic [CW-1:0]       dc_val;
  logic                xfer;

  logic                ov_q;
  logic                ir_q;
  logic                eob_q;
  logic [RUN_W-1:0]    run_q;
  logic [CW-1:0]       val_q;

  assign xfer          = ov_q & bus.out_ready;
  assign bus.in_ready  = ir_q;
  assign bus.out_valid = ov_q;
  assign bus.out_eob   = eob_q;
  assign bus.out_run   = run_q;
  assign bus.out_value = val_q;

  coeff_rle_sel #(.NCOEF(NCOEF), .CW(CW), .IW(IW)) u_sel (
    .blk  (blk),
    .idx  (idx),
    .coef (coef),
    .nz   (nz)
  );

`ifdef COEFF_RLE_DC_DIFF_EN
  logic [CW-1:0] prev_dc;

  assign dc_val = coef - prev_dc;

  // Predictor follows the DC actually handed to the consumer, so it moves on transfer.
  always_ff @(posedge clk) begin
    if (!rst_n)
      prev_dc <= '0;
    else if (state == EMIT && xfer && idx == '0)
      prev_dc <= blk[CW-1:0];
  end
`else
  assign dc_val = coef;
`endif

  // Block data needs no reset: it is only read after an accept has loaded it.
  always_ff @(posedge clk) begin
    if (ir_q && bus.in_valid)
      blk <= bus.in_coeffs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      run   <= '0;
      ov_q  <= 1'b0;
      ir_q  <= 1'b1;
      eob_q <= 1'b0;
      run_q <= '0;
      val_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            idx   <= '0;
            run   <= '0;
            ir_q  <= 1'b0;
            state <= SCAN;
          end
        end
        SCAN: begin
          // DC is always emitted, even when zero.
          if (idx == '0 || nz) begin
            ov_q  <= 1'b1;
            eob_q <= 1'b0;
            run_q <= run;
            val_q <= (idx == '0) ? dc_val : coef;
            state <= EMIT;
          end else if (idx == LAST) begin
            ov_q  <= 1'b1;
            eob_q <= 1'b1;
            run_q <= '0;
            val_q <= '0;
            state <= EOB;
          end else begin
            run <= run + 1'b1;
            idx <= idx + 1'b1;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (idx == LAST) begin
              eob_q <= 1'b1;
              run_q <= '0;
              val_q <= '0;
              state <= EOB;
            end else begin
              ov_q  <= 1'b0;
              idx   <= idx + 1'b1;
              run   <= '0;
              state <= SCAN;
            end
          end
        end
        EOB: begin
          if (xfer) begin
            ov_q  <= 1'b0;
            eob_q <= 1'b0;
            ir_q  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_rle.sv
// tb/tb_coeff_rle.sv - self-checking bench for coeff_rle
//
// Purpose: table of directed blocks with hand-computed token lists, plus sequences
//          for mid-block reset and back-to-back dense blocks.
// Options: COEFF_RLE_DC_DIFF_EN changes the expected DC values.
module tb_coeff_rle;
  localparam int NC = 32;
  localparam int W  = 64;

  typedef struct packed {
    logic [5:0]  run;
    logic [63:0] val;
    logic        eob;
  } tok_t;

  typedef struct {
    logic [NC*W-1:0] coeffs;
    int              stall;
    int              ntok;
    bit              keep;
    bit              lat;
    tok_t [5:0]      exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   first_valid;
  tok_t got[$];
  tok_t exp_q[$];

  coeff_rle_if #(.NCOEF(NC), .CW(W)) bus ();

  coeff_rle #(.NCOEF(NC), .CW(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tok_t mk(input int r, input logic [63:0] v, input bit e);
    tok_t t;
    t.run = r[5:0];
    t.val = v;
    t.eob = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_eob", bus.out_eob, 1'b0);
    check("rst_out_run", bus.out_run, 6'd0);
    check("rst_out_value", bus.out_value, 64'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
  endtask

  // Returns 1 ns after the accept edge.
  task automatic send_block(input logic [NC*W-1:0] c);
    int g = 0;
    @(negedge clk);
    bus.in_coeffs = c;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("accept_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Collects tokens until nblk EOB tokens have transferred; stalls each token stall cycles.
  task automatic collect(input int stall, input int nblk);
    int   cyc    = 0;
    int   waited = 0;
    int   neob   = 0;
    tok_t cur;
    tok_t held;
    got.delete();
    first_valid = -1;
    bus.out_ready = (stall == 0);
    while (neob < nblk && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        cur = mk(int'(bus.out_run), bus.out_value, bus.out_eob);
        if (waited > 0) check("stall_hold", cur, held);
        check("in_ready_low_busy", bus.in_ready, 1'b0);
        if (waited < stall) begin
          held = cur;
          waited++;
          bus.out_ready = 1'b0;
        end else begin
          bus.out_ready = 1'b1;
          got.push_back(cur);
          waited = 0;
          if (cur.eob) neob++;
        end
      end else begin
        bus.out_ready = (stall == 0);
      end
    end
    if (neob < nblk) check("collect_timeout", neob, nblk);
  endtask

  vec_t            vecs[6];
  logic [NC*W-1:0] c;
  logic [NC*W-1:0] dense[4];
  logic [63:0]     dc2;
  logic [63:0]     dc3;
  logic [63:0]     prev;
  logic [63:0]     v;
  int              n;
  int              g;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_coeffs = '0;
    bus.out_ready = 1'b1;

`ifdef COEFF_RLE_DC_DIFF_EN
    dc2 = -64'sd6;
    dc3 = 64'd0;
`else
    dc2 = 64'd4;
    dc3 = 64'd4;
`endif

    for (int i = 0; i < 6; i++) begin
      vecs[i].coeffs = '0;
      vecs[i].stall  = 0;
      vecs[i].keep   = 1'b0;
      vecs[i].lat    = 1'b0;
      vecs[i].exp    = '0;
      vecs[i].ntok   = 2;
    end
    // single coefficient
    vecs[0].coeffs[0 +: W] = 64'd5;
    vecs[0].lat    = 1'b1;
    vecs[0].exp[0] = mk(0, 64'd5, 1'b0);
    vecs[0].exp[1] = mk(0, 64'd0, 1'b1);
    // sparse
    c = '0;
    c[0*W +: W]  = -64'sd3;
    c[1*W +: W]  = 64'd7;
    c[4*W +: W]  = -64'sd1;
    c[31*W +: W] = 64'd2;
    vecs[1].coeffs = c;
    vecs[1].lat    = 1'b1;
    vecs[1].ntok   = 5;
    vecs[1].exp[0] = mk(0, -64'sd3, 1'b0);
    vecs[1].exp[1] = mk(0, 64'd7, 1'b0);
    vecs[1].exp[2] = mk(2, -64'sd1, 1'b0);
    vecs[1].exp[3] = mk(26, 64'd2, 1'b0);
    vecs[1].exp[4] = mk(0, 64'd0, 1'b1);
    // sparse under backpressure
    vecs[2] = vecs[1];
    vecs[2].stall = 3;
    vecs[2].lat   = 1'b0;
    // DC sequence 10, 4, 4 without reset in between
    vecs[3].coeffs[0 +: W] = 64'd10;
    vecs[3].lat    = 1'b1;
    vecs[3].exp[0] = mk(0, 64'd10, 1'b0);
    vecs[3].exp[1] = mk(0, 64'd0, 1'b1);
    vecs[4].coeffs[0 +: W] = 64'd4;
    vecs[4].keep   = 1'b1;
    vecs[4].exp[0] = mk(0, dc2, 1'b0);
    vecs[4].exp[1] = mk(0, 64'd0, 1'b1);
    vecs[5].coeffs[0 +: W] = 64'd4;
    vecs[5].keep   = 1'b1;
    vecs[5].exp[0] = mk(0, dc3, 1'b0);
    vecs[5].exp[1] = mk(0, 64'd0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].keep) do_reset();
      send_block(vecs[i].coeffs);
      collect(vecs[i].stall, 1);
      check($sformatf("v%0d_ntok", i), got.size(), vecs[i].ntok);
      for (int k = 0; k < vecs[i].ntok && k < got.size(); k++)
        check($sformatf("v%0d_tok%0d", i, k), got[k], vecs[i].exp[k]);
      if (vecs[i].lat) check($sformatf("v%0d_dc_latency", i), first_valid, 2);
      @(negedge clk);
      check($sformatf("v%0d_ready_after_eob", i), bus.in_ready, 1'b1);
    end

    // Reset while the third token of the sparse block is presented.
    do_reset();
    send_block(vecs[1].coeffs);
    bus.out_ready = 1'b1;
    n = 0;
    g = 0;
    while (n < 3 && g < 200) begin
      @(negedge clk);
      g++;
      if (bus.out_valid) n++;
    end
    check("midrst_reach_tok3", n, 3);
    check("midrst_tok3", mk(int'(bus.out_run), bus.out_value, bus.out_eob), mk(2, -64'sd1, 1'b0));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    c = '0;
    c[0 +: W] = 64'd9;
    send_block(c);
    collect(0, 1);
    check("midrst_ntok", got.size(), 2);
    if (got.size() == 2) begin
      check("midrst_dc", got[0], mk(0, 64'd9, 1'b0));
      check("midrst_eob", got[1], mk(0, 64'd0, 1'b1));
    end

    // Back-to-back dense blocks with in_valid held high.
    do_reset();
    exp_q.delete();
    prev = '0;
    for (int b = 0; b < 4; b++) begin
      dense[b] = '0;
      for (int i = 0; i < NC; i++) begin
        v = 64'(i + 1 + 16 * b);
        dense[b][i*W +: W] = v;
`ifdef COEFF_RLE_DC_DIFF_EN
        if (i == 0) begin
          exp_q.push_back(mk(0, v - prev, 1'b0));
          prev = v;
        end else begin
          exp_q.push_back(mk(0, v, 1'b0));
        end
`else
        exp_q.push_back(mk(0, v, 1'b0));
`endif
      end
      exp_q.push_back(mk(0, 64'd0, 1'b1));
    end
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          int gw = 0;
          bus.in_coeffs = dense[b];
          bus.in_valid  = 1'b1;
          while (!bus.in_ready && gw < 2000) begin
            @(negedge clk);
            gw++;
          end
          @(posedge clk);
          #1;
        end
        bus.in_valid = 1'b0;
      end
      collect(0, 4);
    join
    check("b2b_ntok", got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      check($sformatf("b2b_tok%0d", k), got[k], exp_q[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coeff_rle.md
COEFF_RLE -- requirements
Module: coeff_rle

Interface
REQ-001 Parameter NCOEF, default 32: coefficients per block, in zig-zag order.
REQ-002 Parameter CW, default 64: coefficient width, two's complement.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  a block is presented on in_coeffs.
REQ-006 in_ready  output  1  the block can accept a new block.
REQ-007 in_coeffs  input  NCOEF*CW  packed coefficients; coefficient i is at bits [i*CW +: CW], and coefficient 0 is DC.
REQ-008 out_valid  output  1  a token is presented.
REQ-009 out_ready  input  1  the consumer accepts the token.
REQ-010 out_run  output  6  count of zero coefficients skipped before out_value.
REQ-011 out_value  output  CW  nonzero coefficient value; DC value may be zero.
REQ-012 out_eob  output  1  the token is end-of-block.

Function
REQ-013 Input handshake:
- A block is accepted on a cycle where in_valid and in_ready are both high.
- in_coeffs is captured into an internal register on that edge.
- in_ready is high only in state IDLE.
REQ-014 Output handshake:
- A token transfers on a cycle where out_valid and out_ready are both high.
- While out_valid is high and out_ready is low, out_run, out_value and out_eob hold their values.
REQ-015 State machine: IDLE, SCAN, EMIT, EOB; the state register holds an index register idx (0..NCOEF-1) and a run counter run.
REQ-016 IDLE:
- On accept: set idx=0 and run=0, then go to SCAN.
REQ-017 SCAN, examining coefficient idx:
- If idx==0, or the coefficient is nonzero (all CW bits tested): load out_run=run and out_value=coef, set out_eob=0, and go to EMIT.
- Otherwise, if idx==NCOEF-1: go to EOB.
- Otherwise: run+1 and idx+1, staying in SCAN.
- Each zero coefficient costs exactly one cycle.
REQ-018 EMIT:
- out_valid is high.
- On transfer with idx==NCOEF-1: go to EOB.
- On other transfers: idx+1, run=0, go to SCAN.
REQ-019 EOB:
- out_valid=1, out_eob=1, out_run=0, out_value=0.
- On transfer, go to IDLE.
REQ-020 Trailing zeros after the last nonzero coefficient are never emitted; the EOB token replaces them.
REQ-021 Every block emits exactly one DC token first (run=0) and exactly one EOB token last.
REQ-022 Latency: the DC token has out_valid high 2 cycles after the accept edge.
REQ-023 A new block is accepted no earlier than the cycle after the EOB transfer.
REQ-024 The maximum run is NCOEF-2 (30), which fits in 6 bits; no run-escape token exists.

Reset
REQ-025 While rst_n is low at a clock edge, the block applies:
- state=IDLE, idx=0, run=0
- out_valid=0, out_eob=0, out_run=0, out_value=0
- in_ready=1 from the first cycle after reset is released.
REQ-026 Reset mid-block discards the block and any pending token without emitting an EOB token; the DC predictor (REQ-027) also clears to 0.

Configuration
REQ-027 Macro COEFF_RLE_DC_DIFF_EN, when defined:
- The DC token carries coef0 minus prev_dc, modulo 2^CW.
- prev_dc updates to coef0 on the DC token transfer.
- prev_dc resets to 0.
REQ-028 Without COEFF_RLE_DC_DIFF_EN, the DC token carries coef0 unchanged, and no prev_dc register exists.

Structure
REQ-029 A shared package coeff_rle_pkg SHALL hold:
- the state enum (IDLE, SCAN, EMIT, EOB)
- constants NCOEF_DEF=32, CW_DEF=64, RUN_W=6.
REQ-030 One sub-module, coeff_rle_sel, SHALL be the combinational coefficient selector (idx to coef plus a nonzero flag); everything else stays in coeff_rle.

Verification
REQ-031 Single-coefficient block: coef0=5, all others 0, out_ready=1.
- Expect tokens (run0,val5,eob0) then (0,0,eob1).
- The DC token is valid 2 cycles after accept.
REQ-032 Sparse block: coef0=-3, coef1=7, coef4=-1, coef31=2, others 0.
- Expect tokens (0,-3), (0,7), (2,-1), (26,2), EOB.
REQ-033 Backpressure: same stimulus as REQ-032, with out_ready low for 3 cycles on each token.
- Token fields are stable while stalled.
- The token sequence is identical to REQ-032.
- in_ready stays low until the EOB transfer.
REQ-034 Reset mid-block: assert rst_n=0 during the third token.
- The next cycle has out_valid=0 and in_ready=1.
- A following block with coef0=9 emits (0,9) then EOB.
REQ-035 With COEFF_RLE_DC_DIFF_EN defined: three blocks with DC values 10, 4, 4.
- Expect DC tokens 10, -6, 0; the EOB token follows each.
REQ-036 Back-to-back: in_valid held high with 4 dense blocks (all coefficients nonzero).
- Each block produces 32 tokens plus EOB.
- No block is lost or duplicated.
